// File: rtl/transport_ack_responder_pkg.sv
// Shared types and constants for the transport ACK responder.
package transport_ack_responder_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_HDR,
    S_DHI,
    S_DLO,
    S_CHK,
    S_DELIVER,
    S_ACK_SOF,
    S_ACK_HDR
  } state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] RESP_ACK = 2'b01;
  localparam logic [1:0] RESP_NAK = 2'b10;

  localparam logic [7:0] SOF_FWD_DEFAULT = 8'hA5;
  localparam logic [7:0] SOF_ACK_DEFAULT = 8'h5A;

  // Frame checksum: XOR of header and both payload bytes.
  function automatic logic [7:0] frame_checksum(input logic [7:0] hdr,
                                                input logic [7:0] hi,
                                                input logic [7:0] lo);
    return hdr ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/transport_frame_timer.sv
// Inter-byte idle timer. o_expired marks the idle cycle that exhausts the
// TIMEOUT budget, so the owner can abort on that same clock edge.
module transport_frame_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  assign o_expired = i_enable && (r_count == LAST_IDLE);

  // Count idle cycles; any accepted byte or leaving the frame restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/transport_ack_responder.sv
// Receive side of the transport byte-frame protocol: parses 5-byte frames,
// filters duplicates/keepalives, hands commands to the session and answers
// every complete frame with a 2-byte ACK/NAK on the reverse link.
//
// state     | meaning
// ----------+------------------------------------------------
// S_HUNT    | waiting for forward SOF
// S_HDR     | waiting for header {cmd,seq}
// S_DHI     | waiting for payload high byte
// S_DLO     | waiting for payload low byte
// S_CHK     | waiting for checksum; classify frame on arrival
// S_DELIVER | holding command until the session is free
// S_ACK_SOF | presenting reverse-link SOF
// S_ACK_HDR | presenting {resp,seq}
module transport_ack_responder
  import transport_ack_responder_pkg::*;
#(
  parameter int         TIMEOUT = 64,
  parameter logic [7:0] SOF_FWD = SOF_FWD_DEFAULT,
  parameter logic [7:0] SOF_ACK = SOF_ACK_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rcvSignal,
  input  logic [7:0]  packetIn,
  input  logic        sessionBusy,
  output logic [1:0]  sendingToSession,
  output logic [15:0] data,
  input  logic        ackBusy,
  output logic        ackSending,
  output logic [7:0]  ackOut,
  output logic [7:0]  err_count
);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cmd;
  logic [5:0] r_seq;
  logic [7:0] r_hi, r_lo;
  logic [1:0] r_resp, w_resp_nxt;
  logic [5:0] r_last_seq;
  logic       r_last_valid;
  logic [7:0] r_err;

  logic w_in_frame, w_tmr_expired, w_err_evt, w_seq_upd, w_set_valid, w_chk_ok;

  assign w_in_frame = (r_state == S_HDR) || (r_state == S_DHI) ||
                      (r_state == S_DLO) || (r_state == S_CHK);
  assign w_chk_ok   = (packetIn == frame_checksum({r_cmd, r_seq}, r_hi, r_lo));
  assign err_count  = r_err;

  transport_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (!w_in_frame || rcvSignal),
    .i_enable  (w_in_frame && !rcvSignal),
    .o_expired (w_tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_HUNT;
    else        r_state <= w_state_nxt;
  end

  // Next state, error events and link outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_resp_nxt       = r_resp;
    w_err_evt        = 1'b0;
    w_seq_upd        = 1'b0;
    w_set_valid      = 1'b0;
    sendingToSession = CMD_NONE;
    data             = '0;
    ackSending       = 1'b0;
    ackOut           = '0;
    case (r_state)
      S_HUNT: if (rcvSignal && packetIn == SOF_FWD) w_state_nxt = S_HDR;
      S_HDR, S_DHI, S_DLO: begin
        if (w_tmr_expired) begin
          w_state_nxt = S_HUNT;
          w_err_evt   = 1'b1;
        end else if (rcvSignal) begin
          w_state_nxt = (r_state == S_HDR) ? S_DHI :
                        (r_state == S_DHI) ? S_DLO : S_CHK;
        end
      end
      S_CHK: begin
        if (w_tmr_expired) begin
          w_state_nxt = S_HUNT;
          w_err_evt   = 1'b1;
        end else if (rcvSignal) begin
          w_state_nxt = S_ACK_SOF;
          w_resp_nxt  = RESP_ACK;
          if (!w_chk_ok) begin
            w_resp_nxt = RESP_NAK;
            w_err_evt  = 1'b1;
          end else if (r_last_valid && r_seq == r_last_seq) begin
            w_resp_nxt = RESP_ACK;
          end else if (r_cmd == CMD_NONE) begin
            w_seq_upd = 1'b1;
          end else begin
            w_seq_upd   = 1'b1;
            w_set_valid = 1'b1;
            w_state_nxt = S_DELIVER;
          end
        end
      end
      S_DELIVER: begin
        w_err_evt = rcvSignal;
        if (!sessionBusy) begin
          sendingToSession = r_cmd;
          data             = {r_hi, r_lo};
          w_resp_nxt       = RESP_ACK;
          w_state_nxt      = S_ACK_SOF;
        end
      end
      S_ACK_SOF: begin
        w_err_evt  = rcvSignal;
        ackSending = 1'b1;
        ackOut     = SOF_ACK;
        if (!ackBusy) w_state_nxt = S_ACK_HDR;
      end
      S_ACK_HDR: begin
        w_err_evt  = rcvSignal;
        ackSending = 1'b1;
        ackOut     = {r_resp, r_seq};
        if (!ackBusy) w_state_nxt = S_HUNT;
      end
      default: w_state_nxt = S_HUNT;
    endcase
  end

  // Frame capture, duplicate tracking and saturating error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd        <= CMD_NONE;
      r_seq        <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_resp       <= '0;
      r_last_seq   <= 6'h3F;
      r_last_valid <= 1'b0;
      r_err        <= '0;
    end else begin
      r_resp <= w_resp_nxt;
      if (rcvSignal && r_state == S_HDR) {r_cmd, r_seq} <= packetIn;
      if (rcvSignal && r_state == S_DHI) r_hi <= packetIn;
      if (rcvSignal && r_state == S_DLO) r_lo <= packetIn;
      if (w_seq_upd)   r_last_seq   <= r_seq;
      if (w_set_valid) r_last_valid <= 1'b1;
      if (w_err_evt && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end

endmodule
